// File: rtl/uart_rx_pkg.sv
// Shared constants, state encoding and helpers for the UART receive frame controller.
package uart_rx_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int PRESCALE_WIDTH = 6;
  localparam int BIT_CNT_WIDTH  = $clog2(DATA_WIDTH);

  localparam logic [BIT_CNT_WIDTH-1:0] BIT_LAST = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_8  = PRESCALE_WIDTH'(8);
  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_16 = PRESCALE_WIDTH'(16);
  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_32 = PRESCALE_WIDTH'(32);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic logic prescale_legal(input logic [PRESCALE_WIDTH-1:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Per-bit edge counter and data bit counter; bit_end marks the last edge of each bit.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic                      data_phase,
  input  logic [PRESCALE_WIDTH-1:0] prescale_q,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic                      bit_end
);

  assign bit_end = enable && (edge_cnt == (prescale_q - PRESCALE_WIDTH'(1)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (!enable || bit_end) edge_cnt <= '0;
      else                    edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);

      // bit_cnt only advances inside the data field and is parked at 0 elsewhere
      if (!data_phase)  bit_cnt <= '0;
      else if (bit_end) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, bit timing, deserialiser, parity and stop checks.
module uart_rx_ctrl
  import uart_rx_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      sampled_bit,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      sample_en,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      busy
);

  rx_state_t                 state;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic [DATA_WIDTH-1:0]     shift;
  logic                      perr_q;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic                      bit_end;

  assign busy      = (state != IDLE);
  assign sample_en = busy;

  uart_rx_edge_bit_cnt u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (busy),
    .data_phase (state == DATA),
    .prescale_q (prescale_q),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .bit_end    (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      prescale_q <= PRESCALE_8;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      shift      <= '0;
      perr_q     <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!RX_IN && prescale_legal(prescale)) begin
            state      <= START;
            prescale_q <= prescale;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            perr_q     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) state <= sampled_bit ? IDLE : DATA;
        end
        DATA: begin
          if (bit_end) begin
            shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_end) begin
            perr_q <= (sampled_bit != ((^shift) ^ (par_typ_q == PAR_ODD)));
            state  <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            state      <= IDLE;
            stp_err    <= ~sampled_bit;
            par_err    <= perr_q;
            data_valid <= sampled_bit & ~perr_q;
            if (sampled_bit && !perr_q) P_DATA <= shift;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
